// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Latency: grant registered 1 cycle after in_valid in IDLE; beats pass to the FIFO combinationally.
// Backpressure: fifo_full combinationally drops in_ready and fifo_wr_en in the same cycle.
//
// Ports:
//   wr_clk, rst          write-domain clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_ready
//                        per-requester beat handshake; requester i data at
//                        in_data[i*FIFO_WIDTH +: FIFO_WIDTH]
//   fifo_full            FIFO full flag (write side)
//   fifo_wr_en/fifo_din  FIFO write enable and data
//   busy                 high while a burst is granted
//   gnt_id               current or most recently granted requester
//   stall_cnt            (only with ARB_STALL_CNT_EN) saturating count of cycles
//                        where the granted requester had data but the FIFO was full
//
// Optional feature macro: ARB_STALL_CNT_EN

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                             wr_clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               in_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]    in_data,
  input  logic [NUM_REQ-1:0]               in_last,
  output logic [NUM_REQ-1:0]               in_ready,
  input  logic                             fifo_full,
  output logic                             fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]            fifo_din,
  output logic                             busy,
`ifdef ARB_STALL_CNT_EN
  output logic [15:0]                      stall_cnt,
`endif
  output logic [$clog2(NUM_REQ)-1:0]       gnt_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [BCW-1:0] beat_cnt;

  // Signals of the granted requester, selected with an explicit compare so
  // that non-power-of-two NUM_REQ never indexes past the request vectors.
  logic                  sel_valid;
  logic                  sel_last;
  logic [FIFO_WIDTH-1:0] sel_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
        sel_data  = in_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  // Round-robin search starting one past the last served requester, so the
  // requester that just finished a burst has the lowest priority next time.
  logic [IDW-1:0] next_gnt;
  logic           found;
  int             idx;

  always_comb begin
    next_gnt = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && in_valid[idx]) begin
        found    = 1'b1;
        next_gnt = IDW'(idx);
      end
    end
  end

  // Beat acceptance is purely combinational on fifo_full: the full flag lags a
  // write by one cycle, so any registered version would overrun the FIFO.
  logic accept;
  logic burst_end;
  logic cnt_at_max;

  assign accept     = (state == ST_BURST) && sel_valid && !fifo_full;
  assign cnt_at_max = (beat_cnt == BCW'(MAX_BURST - 1));
  assign burst_end  = accept && (sel_last || cnt_at_max);

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state == ST_BURST) && (gnt_id == IDW'(i))) begin
        in_ready[i] = !fifo_full;
      end
    end
  end

  assign fifo_wr_en = accept;
  assign fifo_din   = accept ? sel_data : '0;

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= IDW'(NUM_REQ - 1);
      gnt_id   <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            gnt_id   <= next_gnt;
            beat_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          // Never preempted: with no accepted beat (requester idle or FIFO
          // full) everything holds until the granted requester resumes.
          if (burst_end) begin
            rr_ptr   <= gnt_id;
            beat_cnt <= '0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else if (accept) begin
            beat_cnt <= beat_cnt + BCW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STALL_CNT_EN
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (busy && sel_valid && fifo_full && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single burst, round-robin order,
// MAX_BURST cut-off, FIFO-full stall, mid-burst reset and requester dropout.

module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int MB = 8;

  logic              wr_clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     in_valid;
  logic [NR*W-1:0]   in_data;
  logic [NR-1:0]     in_last;
  logic [NR-1:0]     in_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [W-1:0]      fifo_din;
  logic              busy;
  logic [1:0]        gnt_id;
`ifdef ARB_STALL_CNT_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       stall_base;
`endif

  int tests = 0;
  int fails = 0;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .FIFO_WIDTH (W),
    .MAX_BURST  (MB)
  ) dut (
    .wr_clk     (wr_clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .busy       (busy),
`ifdef ARB_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .gnt_id     (gnt_id)
  );

  task automatic chk(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
    end
  endtask

  // Requester i, beat b carries a unique word so lost/duplicated beats show up.
  function automatic logic [15:0] pat(input int i, input int b);
    return 16'((i + 1) * 4096 + 160 + b);
  endfunction

  task automatic tick;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic set_beat(input int b, input bit last);
    for (int i = 0; i < NR; i++) in_data[i*W +: W] = pat(i, b);
    in_last = last ? '1 : '0;
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk(tag, "idle_busy",  32'(busy),       32'd0);
    chk(tag, "idle_wr_en", 32'(fifo_wr_en), 32'd0);
    chk(tag, "idle_ready", 32'(in_ready),   32'd0);
    chk(tag, "idle_din",   32'(fifo_din),   32'd0);
  endtask

  task automatic chk_beat(input string tag, input int g, input int b);
    #1;
    chk(tag, "busy",  32'(busy),       32'd1);
    chk(tag, "gnt",   32'(gnt_id),     32'(g));
    chk(tag, "wr_en", 32'(fifo_wr_en), 32'd1);
    chk(tag, "din",   32'(fifo_din),   32'(pat(g, b)));
    chk(tag, "ready", 32'(in_ready),   32'(1 << g));
  endtask

  task automatic chk_hold(input string tag, input int g, input logic [3:0] exp_rdy);
    #1;
    chk(tag, "busy",  32'(busy),       32'd1);
    chk(tag, "gnt",   32'(gnt_id),     32'(g));
    chk(tag, "wr_en", 32'(fifo_wr_en), 32'd0);
    chk(tag, "ready", 32'(in_ready),   32'(exp_rdy));
    chk(tag, "din",   32'(fifo_din),   32'd0);
  endtask

  // One IDLE bubble, grant, then n accepted beats.
  task automatic run_burst(input string tag, input int g, input int n, input bit last_at_end);
    set_beat(0, 1'b0);
    chk_idle(tag);
    tick;
    for (int b = 0; b < n; b++) begin
      set_beat(b, last_at_end && (b == n - 1));
      chk_beat($sformatf("%s.b%0d", tag, b), g, b);
      tick;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    fifo_full = 1'b0;
    tick;
    tick;

    // Reset state
    #1;
    chk("rst", "busy",  32'(busy),       32'd0);
    chk("rst", "gnt",   32'(gnt_id),     32'd0);
    chk("rst", "wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst", "ready", 32'(in_ready),   32'd0);
    chk("rst", "din",   32'(fifo_din),   32'd0);
`ifdef ARB_STALL_CNT_EN
    chk("rst", "stall", 32'(stall_cnt),  32'd0);
`endif
    rst = 1'b0;

    // 1: single 3-beat burst from requester 0
    in_valid = 4'b0001;
    run_burst("t1", 0, 3, 1'b1);
    in_valid = 4'b0000;
    chk_idle("t1.end");
    tick;
    chk("t1.hold", "gnt", 32'(gnt_id), 32'd0);

    // 2: all requesters, 2-beat bursts, order 0,1,2,3,0 from reset
    rst = 1'b1;
    tick;
    rst = 1'b0;
    in_valid = 4'b1111;
    run_burst("t2.g0", 0, 2, 1'b1);
    run_burst("t2.g1", 1, 2, 1'b1);
    run_burst("t2.g2", 2, 2, 1'b1);
    run_burst("t2.g3", 3, 2, 1'b1);
    run_burst("t2.g0b", 0, 2, 1'b1);
    in_valid = 4'b0000;
    tick;

    // 3: requester 2 never asserts last -> cut at MAX_BURST, then re-granted
    in_valid = 4'b0100;
    run_burst("t3", 2, MB, 1'b0);
    run_burst("t3r", 2, 2, 1'b1);
    in_valid = 4'b0000;
    tick;

    // 4: FIFO full for 5 cycles mid-burst on requester 1
    in_valid = 4'b0010;
    set_beat(0, 1'b0);
    chk_idle("t4");
    tick;
    chk_beat("t4.b0", 1, 0);
    tick;
    set_beat(1, 1'b0);
    chk_beat("t4.b1", 1, 1);
    tick;
`ifdef ARB_STALL_CNT_EN
    stall_base = stall_cnt;
`endif
    set_beat(2, 1'b0);
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk_hold($sformatf("t4.full%0d", c), 1, 4'b0000);
      tick;
    end
    fifo_full = 1'b0;
    chk_beat("t4.b2", 1, 2);
    tick;
    set_beat(3, 1'b1);
    chk_beat("t4.b3", 1, 3);
    tick;
    in_valid = 4'b0000;
    chk_idle("t4.end");
`ifdef ARB_STALL_CNT_EN
    chk("t4", "stall", 32'(stall_cnt), 32'(stall_base + 16'd5));
`endif
    tick;

    // 5: reset at beat 2 of requester 3's burst; next grant goes to 0
    in_valid = 4'b1000;
    set_beat(0, 1'b0);
    chk_idle("t5");
    tick;
    chk_beat("t5.b0", 3, 0);
    tick;
    set_beat(1, 1'b0);
    chk_beat("t5.b1", 3, 1);
    tick;
    set_beat(2, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    in_valid = 4'b1001;
    chk("t5.rst", "gnt", 32'(gnt_id), 32'd0);
`ifdef ARB_STALL_CNT_EN
    chk("t5.rst", "stall", 32'(stall_cnt), 32'd0);
`endif
    run_burst("t5.g0", 0, 2, 1'b1);
    run_burst("t5.g3", 3, 1, 1'b1);
    in_valid = 4'b0000;
    tick;

    // 6: requester 1 drops valid for 3 cycles while 3 waits; no switch
    in_valid = 4'b1010;
    set_beat(0, 1'b0);
    chk_idle("t6");
    tick;
    chk_beat("t6.b0", 1, 0);
    tick;
    set_beat(1, 1'b0);
    in_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      chk_hold($sformatf("t6.gap%0d", c), 1, 4'b0010);
      tick;
    end
    in_valid = 4'b1010;
    set_beat(1, 1'b1);
    chk_beat("t6.b1", 1, 1);
    tick;
    run_burst("t6.g3", 3, 1, 1'b1);
    in_valid = 4'b0000;
    chk_idle("t6.end");
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
